digest_serializer: RTL
======================

DIGEST_SERIALIZER -- requirements
Module: digest_serializer

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 hash_valid  input  1  final hash state from the HCU is available.
REQ-005 hash_ready  output  1  serializer can accept a hash state.
REQ-006 hash_mode  input  1  0 = SHA-256 (low 32 bits of each word used), 1 = SHA-512; sampled at capture.
REQ-007 hash_data  input  512  H0..H7, 64 bits each, H0 in bits [511:448].
REQ-008 out_tdata  output  64  digest beat.
REQ-009 out_tvalid  output  1  beat valid.
REQ-010 out_tready  input  1  downstream accepts beat.
REQ-011 out_tlast  output  1  final beat of the digest.
REQ-012 out_tkeep  output  8  byte-valid mask; bit 7 = out_tdata[63:56].
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE and SEND.
REQ-015 hash_ready SHALL be registered and high only in IDLE.
REQ-016 Capture SHALL occur on hash_valid & hash_ready at edge N: register hash_data and hash_mode, clear beat counter, enter SEND; out_tvalid high from cycle N+1.
REQ-017 SHA-512 SHALL emit 8 beats; beat k = Hk[63:0].
REQ-018 SHA-256 SHALL emit 4 beats; beat k = {H(2k)[31:0], H(2k+1)[31:0]}.
REQ-019 out_tkeep SHALL be 8'hFF on every beat unless REQ-030 applies.
REQ-020 A beat SHALL advance only on out_tvalid & out_tready; out_tdata/out_tlast/out_tkeep SHALL hold stable while out_tvalid & !out_tready.
REQ-021 out_tlast SHALL be high only on the final beat.
REQ-022 After the final-beat handshake, the FSM SHALL return to IDLE; out_tvalid low and hash_ready high on the next cycle. Back-to-back digests are separated by exactly one idle cycle.
REQ-023 hash_valid in SEND SHALL be ignored; captured data SHALL not change during SEND.
REQ-024 The beat counter SHALL be 3 bits and SHALL never wrap past the mode's final beat.
REQ-025 With out_tready held high, a digest SHALL complete in 8 (SHA-512) or 4 (SHA-256) consecutive cycles.

Reset
REQ-026 resetn low SHALL immediately force IDLE and set out_tvalid, out_tlast, busy and hash_ready to 0, and out_tdata and out_tkeep to all zeros.
REQ-027 hash_ready SHALL rise on the first clock edge after resetn deasserts.
REQ-028 Reset during SEND SHALL abort the digest with no further beats; no partial-state resumption.

Configuration
REQ-029 Macro DIGEST_TRUNC_EN SHALL add input port hash_trunc (1 bit, sampled at capture).
REQ-030 With DIGEST_TRUNC_EN defined and hash_trunc=1:
- SHA-512 mode SHALL emit 6 beats (H0..H5, SHA-384).
- SHA-256 mode SHALL emit 4 beats covering H0..H6 (SHA-224); the final beat is {H6[31:0], 32'h0} with out_tkeep 8'hF0.
REQ-031 Without DIGEST_TRUNC_EN, the hash_trunc port SHALL be absent and behaviour SHALL be as REQ-017/018.

Verification
REQ-032 SHA-256 "abc" state (H0=ba7816bf ... H7=f20015ad), out_tready=1 -> 4 beats, beat0=64'hba7816bf8f01cfea, beat3=64'hb410ff61f20015ad with tlast, tkeep=8'hFF.
REQ-033 SHA-512 "abc" state, out_tready toggling 1,0,1,0 -> 8 beats, beat0=64'hddaf35a193617aba, data stable during stalls, tlast on beat 7 only.
REQ-034 hash_valid held high across two digests -> second capture occurs one cycle after first tlast handshake; hash_ready=0 throughout SEND.
REQ-035 resetn pulsed low after beat 2 of SHA-512 -> out_tvalid=0 immediately, no beat 3, hash_ready=1 one edge after release.
REQ-036 DIGEST_TRUNC_EN, SHA-384 "abc" state, hash_trunc=1 -> 6 beats, beat0=64'hcb00753f45a35e8b, tlast on beat 5.
REQ-037 DIGEST_TRUNC_EN, SHA-224 state, hash_trunc=1 -> beat3={H6,32'h0}, tkeep=8'hF0, tlast=1.

Source files
------------

// File: rtl/digest_serializer.sv
// digest_serializer: streams a captured SHA-256/512 final hash state as 64-bit AXI-Stream beats.
// Optional DIGEST_TRUNC_EN adds hash_trunc for SHA-224/SHA-384 truncated output.
module digest_serializer (
  input  logic         clk,
  input  logic         resetn,
  input  logic         hash_valid,
  output logic         hash_ready,
  input  logic         hash_mode,
  input  logic [511:0] hash_data,
`ifdef DIGEST_TRUNC_EN
  input  logic         hash_trunc,
`endif
  output logic [63:0]  out_tdata,
  output logic         out_tvalid,
  input  logic         out_tready,
  output logic         out_tlast,
  output logic [7:0]   out_tkeep,
  output logic         busy
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;
  logic [511:0] data_q;
  logic mode_q, trunc_q, trunc_in, cap, fire, pad;
  logic [2:0] cnt, last_idx;
  logic [63:0] h [8];
  logic [63:0] beat;
`ifdef DIGEST_TRUNC_EN
  assign trunc_in = hash_trunc;
`else
  assign trunc_in = 1'b0;
`endif
  always_comb for (int i = 0; i < 8; i++) h[i] = data_q[511-64*i -: 64];
  always_comb begin
    cap = hash_valid & hash_ready;
    out_tvalid = state == SEND;
    busy = state != IDLE;
    fire = out_tvalid & out_tready;
    last_idx = mode_q ? (trunc_q ? 3'd5 : 3'd7) : 3'd3;
    out_tlast = out_tvalid && cnt == last_idx;
    // SHA-224 last beat carries only H6; its low half is padding
    pad = trunc_q & ~mode_q & out_tlast;
    beat = mode_q ? h[cnt] : {h[{cnt[1:0], 1'b0}][31:0], pad ? 32'h0 : h[{cnt[1:0], 1'b1}][31:0]};
    out_tdata = out_tvalid ? beat : 64'h0;
    out_tkeep = out_tvalid ? (pad ? 8'hF0 : 8'hFF) : 8'h00;
    state_nx = (state == IDLE && cap) ? SEND : (fire && out_tlast) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      hash_ready <= 1'b0;
      data_q <= '0;
      mode_q <= 1'b0;
      trunc_q <= 1'b0;
      cnt <= 3'd0;
    end else begin
      state <= state_nx;
      hash_ready <= state_nx == IDLE;
      if (cap) begin
        data_q <= hash_data;
        mode_q <= hash_mode;
        trunc_q <= trunc_in;
        cnt <= 3'd0;
      end else if (fire && !out_tlast) begin
        cnt <= cnt + 3'd1;
      end
    end
  end
endmodule
